// File: rtl/ising_pkg.sv
// Shared definitions for the coupled-oscillator array control path:
// run-controller state encodings and default counter/synchronizer sizing.
package ising_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HOLD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        HOLD   = ST_HOLD,
        RUN    = ST_RUN,
        SAMPLE = ST_SAMPLE,
        DONE   = ST_DONE
    } state_e;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage flip-flop synchronizer for one asynchronous bit; clears to 0.
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    // NOTE: clocked state uses non-blocking (<=) so every stage samples the
    // value its neighbour held before the edge, giving a true shift chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/phase_sampler.sv
// Run controller and majority-vote spin readout for the oscillator array.
// Build option: define PHASE_SAMPLER_TIE_HOLD_EN to keep the previous spin on a tie.
module phase_sampler
    import ising_pkg::*;
#(
    parameter int NUM_SPINS   = 8,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                 clk,
    input  logic                 axi_rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     hold_cycles,
    input  logic [CNT_W-1:0]     anneal_cycles,
    input  logic [CNT_W-1:0]     window_cycles,
    input  logic [NUM_SPINS-1:0] osc_in,
    input  logic                 ref_osc,
    output logic                 ising_rstn,
    output logic                 busy,
    output logic                 done,
    output logic                 valid,
    output logic [NUM_SPINS-1:0] spins
);

`ifdef PHASE_SAMPLER_TIE_HOLD_EN
    localparam logic TIE_HOLD = 1'b1;
`else
    localparam logic TIE_HOLD = 1'b0;
`endif

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [NUM_SPINS-1:0] sync_osc;
    logic                 sync_ref;
    logic [NUM_SPINS-1:0] mm;

    for (genvar i = 0; i < NUM_SPINS; i++) begin : g_sync_osc
        sync_ff #(.STAGES(SYNC_STAGES)) u_sync_osc (
            .clk (clk),
            .rst (axi_rst),
            .d_i (osc_in[i]),
            .q_o (sync_osc[i])
        );
    end

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_ref (
        .clk (clk),
        .rst (axi_rst),
        .d_i (ref_osc),
        .q_o (sync_ref)
    );

    // Both paths see the same synchronizer lag, so relative phase is intact.
    assign mm = sync_osc ^ {NUM_SPINS{sync_ref}};

    state_e               state_q;
    logic [CNT_W-1:0]     timer_q;
    logic [CNT_W-1:0]     anneal_q;
    logic [CNT_W-1:0]     window_q;
    logic [CNT_W-1:0]     cnt_q [NUM_SPINS];
    logic [CNT_W-1:0]     cnt_d [NUM_SPINS];
    logic [NUM_SPINS-1:0] spins_q;
    logic [NUM_SPINS-1:0] spins_d;
    logic                 ising_rstn_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 valid_q;

    // Vote includes the final window sample; compare 2*count against W' at CNT_W+1 bits.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        spins_d = '0;
        for (int i = 0; i < NUM_SPINS; i++) begin
            cnt_d[i]   = cnt_q[i] + CNT_W'(mm[i]);
            spins_d[i] = ({cnt_d[i], 1'b0} > {1'b0, window_q})
                       | (({cnt_d[i], 1'b0} == {1'b0, window_q}) & TIE_HOLD & spins_q[i]);
        end
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            anneal_q     <= '0;
            window_q     <= '0;
            spins_q      <= '0;
            ising_rstn_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            valid_q      <= 1'b0;
            // NOTE: the per-spin counters are a handful of flops, not a RAM,
            // so they are reset like any other register.
            for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q      <= HOLD;
                        busy_q       <= 1'b1;
                        ising_rstn_q <= 1'b0;
                        valid_q      <= 1'b0;
                        timer_q      <= (hold_cycles == '0) ? '0 : hold_cycles - ONE;
                        anneal_q     <= anneal_cycles;
                        window_q     <= (window_cycles == '0) ? ONE : window_cycles;
                    end
                end
                HOLD: begin
                    if (timer_q == '0) begin
                        ising_rstn_q <= 1'b1;
                        if (anneal_q == '0) begin
                            state_q <= SAMPLE;
                            timer_q <= window_q - ONE;
                            for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= '0;
                        end else begin
                            state_q <= RUN;
                            timer_q <= anneal_q - ONE;
                        end
                    end else begin
                        timer_q <= timer_q - ONE;
                    end
                end
                RUN: begin
                    if (timer_q == '0) begin
                        state_q <= SAMPLE;
                        timer_q <= window_q - ONE;
                        for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= '0;
                    end else begin
                        timer_q <= timer_q - ONE;
                    end
                end
                SAMPLE: begin
                    for (int i = 0; i < NUM_SPINS; i++) cnt_q[i] <= cnt_d[i];
                    if (timer_q == '0) begin
                        state_q      <= DONE;
                        spins_q      <= spins_d;
                        valid_q      <= 1'b1;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        ising_rstn_q <= 1'b0;
                    end else begin
                        timer_q <= timer_q - ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ising_rstn = ising_rstn_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign valid      = valid_q;
    assign spins      = spins_q;

endmodule

// File: tb/tb_phase_sampler.sv
// Table-driven, scoreboarded bench for phase_sampler (run timing, vote, tie, reset).
module tb_phase_sampler;

    localparam int N  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          axi_rst;
    logic          start;
    logic [CW-1:0] hold_cycles, anneal_cycles, window_cycles;
    logic [N-1:0]  osc_in;
    logic          ref_osc;
    logic          ising_rstn, busy, done, valid;
    logic [N-1:0]  spins;

    phase_sampler #(.NUM_SPINS(N), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .axi_rst       (axi_rst),
        .start         (start),
        .hold_cycles   (hold_cycles),
        .anneal_cycles (anneal_cycles),
        .window_cycles (window_cycles),
        .osc_in        (osc_in),
        .ref_osc       (ref_osc),
        .ising_rstn    (ising_rstn),
        .busy          (busy),
        .done          (done),
        .valid         (valid),
        .spins         (spins)
    );

    always #5 clk = ~clk;

    // Oscillator model: reference square wave, spins either static copies
    // (optionally inverted) or flipping every cycle relative to the reference.
    logic [N-1:0] inv_mask = '0;
    logic [N-1:0] alt_mask = '0;
    logic         alt      = 1'b0;
    logic         ref_ph   = 1'b0;
    int           ref_cnt  = 0;

    initial begin
        osc_in  = '0;
        ref_osc = 1'b0;
        forever begin
            @(negedge clk);
            alt = ~alt;
            ref_cnt++;
            if (ref_cnt == 3) begin
                ref_cnt = 0;
                ref_ph  = ~ref_ph;
            end
            ref_osc = ref_ph;
            osc_in  = {N{ref_ph}} ^ inv_mask ^ (alt ? alt_mask : '0);
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [CW-1:0] h;
        logic [CW-1:0] a;
        logic [CW-1:0] w;
        logic [N-1:0]  inv;
        logic [N-1:0]  alt;
        int            pulse_at;
        logic [N-1:0]  exp_spins;
    } vec_t;

    typedef struct {
        logic [N-1:0] spins;
        int           lat;
    } sb_t;

    sb_t          sb_q[$];
    logic [N-1:0] prev_spins = '0;

    task automatic do_run(input vec_t v, input string tag);
        int   h_eff, w_eff, lat, dones, bad_n;
        logic trace_ok;
        sb_t  e;
        h_eff = (v.h == 0) ? 1 : int'(v.h);
        w_eff = (v.w == 0) ? 1 : int'(v.w);
        lat   = h_eff + int'(v.a) + w_eff + 1;
        inv_mask = v.inv;
        alt_mask = v.alt;
        repeat (4) tick();
        hold_cycles   = v.h;
        anneal_cycles = v.a;
        window_cycles = v.w;
        sb_q.push_back('{spins: v.exp_spins, lat: lat});
        start = 1'b1;
        tick();
        start = 1'b0;
        // Shadowed configuration must ignore these later changes.
        hold_cycles   = CW'($urandom_range(1, 200));
        anneal_cycles = CW'($urandom_range(1, 200));
        window_cycles = CW'($urandom_range(1, 200));
        trace_ok = 1'b1;
        bad_n    = 0;
        dones    = 0;
        for (int n = 1; n <= lat + 3; n++) begin
            if (busy !== (n < lat) || ising_rstn !== (n > h_eff && n < lat) ||
                done !== (n == lat) || valid !== (n >= lat) ||
                (n < lat && spins !== prev_spins)) begin
                if (trace_ok) bad_n = n;
                trace_ok = 1'b0;
            end
            if (done === 1'b1) begin
                dones++;
                if (sb_q.size() == 0) begin
                    check({tag, " sb_underflow"}, 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check({tag, " spins"}, 32'(spins), 32'(e.spins));
                    check({tag, " latency"}, 32'(n), 32'(e.lat));
                end
            end
            start = (n == v.pulse_at);
            tick();
        end
        start = 1'b0;
        if (!trace_ok) $display("  %s trace deviates first at cycle %0d", tag, bad_n);
        check({tag, " trace"}, 32'(trace_ok), 32'd1);
        check({tag, " done_count"}, 32'(dones), 32'd1);
        check({tag, " sb_empty"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        prev_spins = v.exp_spins;
    endtask

    vec_t vecs[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dones;
        vecs[0] = '{h: 3, a: 5, w: 8,  inv: 8'h00, alt: 8'h00, pulse_at: 0, exp_spins: 8'h00};
        vecs[1] = '{h: 3, a: 5, w: 8,  inv: 8'h5A, alt: 8'h00, pulse_at: 0, exp_spins: 8'h5A};
        vecs[2] = '{h: 0, a: 0, w: 0,  inv: 8'hFF, alt: 8'h00, pulse_at: 0, exp_spins: 8'hFF};
        vecs[3] = '{h: 2, a: 0, w: 64, inv: 8'h02, alt: 8'h00, pulse_at: 0, exp_spins: 8'h02};
        vecs[4] = '{h: 1, a: 3, w: 8,  inv: 8'h04, alt: 8'h00, pulse_at: 0, exp_spins: 8'h04};
`ifdef PHASE_SAMPLER_TIE_HOLD_EN
        vecs[5] = '{h: 1, a: 3, w: 8,  inv: 8'h02, alt: 8'h04, pulse_at: 0, exp_spins: 8'h06};
`else
        vecs[5] = '{h: 1, a: 3, w: 8,  inv: 8'h02, alt: 8'h04, pulse_at: 0, exp_spins: 8'h02};
`endif
        vecs[6] = '{h: 5, a: 7, w: 9,  inv: 8'h81, alt: 8'h00, pulse_at: 8, exp_spins: 8'h81};
        vecs[7] = '{h: 0, a: 1, w: 1,  inv: 8'h3C, alt: 8'h00, pulse_at: 0, exp_spins: 8'h3C};
        // Run after a mid-flight reset: previous spins are 0, so the tie on bit 5 gives 0.
        vecs[8] = '{h: 2, a: 2, w: 6,  inv: 8'h11, alt: 8'h20, pulse_at: 0, exp_spins: 8'h11};

        axi_rst       = 1'b1;
        start         = 1'b0;
        hold_cycles   = '0;
        anneal_cycles = '0;
        window_cycles = '0;
        repeat (3) tick();
        check("reset ising_rstn", 32'(ising_rstn), 32'd0);
        check("reset busy",       32'(busy),       32'd0);
        check("reset done",       32'(done),       32'd0);
        check("reset valid",      32'(valid),      32'd0);
        check("reset spins",      32'(spins),      32'd0);
        axi_rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) do_run(vecs[i], $sformatf("vec%0d", i));

        // Mid-SAMPLE reset with H=4, A=10, W=20: SAMPLE spans cycles 16..35.
        inv_mask = 8'h99;
        alt_mask = 8'h00;
        repeat (4) tick();
        hold_cycles   = 4;
        anneal_cycles = 10;
        window_cycles = 20;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        check("mid_run busy", 32'(busy), 32'd1);
        check("mid_run valid_cleared", 32'(valid), 32'd0);
        axi_rst = 1'b1;
        #1;
        check("async_rst outputs", 32'({ising_rstn, busy, done, valid, spins}), 32'd0);
        tick();
        check("rst_held outputs", 32'({ising_rstn, busy, done, valid, spins}), 32'd0);
        axi_rst = 1'b0;
        dones = 0;
        for (int n = 0; n < 40; n++) begin
            if (done === 1'b1 || busy === 1'b1) dones++;
            tick();
        end
        check("post_rst idle", 32'(dones), 32'd0);
        check("post_rst spins", 32'(spins), 32'd0);
        prev_spins = '0;

        do_run(vecs[8], "vec8");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
